// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the note-code path.
//
// Holds the 4-bit note-code constants (also used by the sequencer and the keypad sources),
// the half-period table for a 10 MHz clock, and the tone-generator state encoding.
package note_tone_gen_pkg;

   // Note codes: semitones from C4 up to C5; 13 and 14 are unused and behave like silence.
   localparam logic [3:0] NOTE_C4     = 4'd0;
   localparam logic [3:0] NOTE_CS4    = 4'd1;
   localparam logic [3:0] NOTE_D4     = 4'd2;
   localparam logic [3:0] NOTE_DS4    = 4'd3;
   localparam logic [3:0] NOTE_E4     = 4'd4;
   localparam logic [3:0] NOTE_F4     = 4'd5;
   localparam logic [3:0] NOTE_FS4    = 4'd6;
   localparam logic [3:0] NOTE_G4     = 4'd7;
   localparam logic [3:0] NOTE_GS4    = 4'd8;
   localparam logic [3:0] NOTE_A4     = 4'd9;
   localparam logic [3:0] NOTE_AS4    = 4'd10;
   localparam logic [3:0] NOTE_B4     = 4'd11;
   localparam logic [3:0] NOTE_C5     = 4'd12;
   localparam logic [3:0] NOTE_SILENT = 4'hF;

   localparam int unsigned NumNotes = 13;

   // Half-period of each note in 10 MHz clock cycles, indexed by note code.
   localparam int unsigned HalfPeriodTable [NumNotes] = '{
      19111, 18039, 17026, 16071, 15169, 14317,
      13514, 12755, 12039, 11364, 10726, 10124, 9556
   };

   // Generator states.
   typedef logic [1:0] state_t;
   localparam state_t StSilent = 2'd0;  // output held low
   localparam state_t StPlay   = 2'd1;  // tone running, input matches current note
   localparam state_t StPend   = 2'd2;  // tone running, change waiting for period end

endpackage

// File: rtl/note_tone_gen_if.sv
// Note-code link between a note source (sequencer/keypad) and the tone generator.
//
// Signals:
//   note_in      note code presented by the source
//   mute         level-sensitive mute request
//   wave_out     square-wave tone
//   tone_active  high while a tone is being generated
//   cur_note     note currently being generated (NOTE_SILENT when silent)
// Modports: master = note source, slave = tone generator.
interface note_tone_gen_if;
   logic [3:0] note_in;
   logic       mute;
   logic       wave_out;
   logic       tone_active;
   logic [3:0] cur_note;

   modport master (
      output note_in,
      output mute,
      input  wave_out,
      input  tone_active,
      input  cur_note
   );

   modport slave (
      input  note_in,
      input  mute,
      output wave_out,
      output tone_active,
      output cur_note
   );
endinterface

// File: rtl/note_period_lut.sv
// Combinational note-code to half-period lookup.
//
// Ports:
//   note_i         note code
//   half_period_o  half-period in clock cycles, already right-shifted by DIV_SHIFT (0 if invalid)
//   valid_o        high for codes 0..12
module note_period_lut
   import note_tone_gen_pkg::*;
#(
   parameter int unsigned DIV_SHIFT = 0,
   parameter int unsigned CNT_W     = 15
) (
   input  logic [3:0]       note_i,
   output logic [CNT_W-1:0] half_period_o,
   output logic             valid_o
);

   // Compare against each table index so out-of-range codes never index past the table.
   always_comb begin
      half_period_o = '0;
      valid_o       = 1'b0;
      for (int unsigned i = 0; i < NumNotes; i++) begin
         if (note_i == 4'(i)) begin
            half_period_o = CNT_W'(HalfPeriodTable[i] >> DIV_SHIFT);
            valid_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/note_tone_gen.sv
// Note-code to square-wave tone generator.
//
// Turns the note code presented on the link into a 50% duty square wave at the note's pitch.
// A running tone only changes note (or stops) at the end of a full period, i.e. at the end of a
// low half, so the output never carries a truncated pulse. Mute drops the output the next cycle.
//
// Ports:
//   clk    system clock (10 MHz nominal)
//   n_rst  asynchronous active-low reset
//   bus    note link, slave side (note_in/mute in; wave_out/tone_active/cur_note out)
// Parameters:
//   DIV_SHIFT  right shift applied to every half-period (each +1 raises the pitch one octave)
//   CNT_W      half-period counter width; must hold the largest table entry
module note_tone_gen
   import note_tone_gen_pkg::*;
#(
   parameter int unsigned DIV_SHIFT = 0,
   parameter int unsigned CNT_W     = 15
) (
   input  logic             clk,
   input  logic             n_rst,
   note_tone_gen_if.slave   bus
);

   state_t           state_q, state_d;
   logic             wave_q, wave_d;
   logic [3:0]       cur_q, cur_d;
   logic [3:0]       pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       lut_idx;
   logic [CNT_W-1:0] lut_hp;
   logic             lut_valid;

   logic             lvl_end;
   logic             pend_apply;
   logic             wave_adv;
   logic [CNT_W-1:0] cnt_adv;

   // Last cycle of the current level.
   assign lvl_end = (cnt_q == '0);

   // End of a full period while a different note is waiting: the pending code takes over.
   // If the input has just returned to the current note, the tone simply carries on.
   assign pend_apply = (state_q == StPend) && lvl_end && !wave_q && (bus.note_in != cur_q);

   // One lookup serves all cases: the new note when starting from silence, the pending note at
   // a change-over, otherwise the current note for the reload at each toggle.
   always_comb begin
      lut_idx = cur_q;
      if (state_q == StSilent) begin
         lut_idx = bus.note_in;
      end else if (pend_apply) begin
         lut_idx = pend_q;
      end
   end

   note_period_lut #(
      .DIV_SHIFT (DIV_SHIFT),
      .CNT_W     (CNT_W)
   ) u_lut (
      .note_i        (lut_idx),
      .half_period_o (lut_hp),
      .valid_o       (lut_valid)
   );

   // Level timing shared by PLAY and PEND: toggle and reload happen in the same cycle, so every
   // level lasts exactly one half-period.
   always_comb begin
      wave_adv = wave_q;
      cnt_adv  = cnt_q - CNT_W'(1);
      if (lvl_end) begin
         wave_adv = ~wave_q;
         cnt_adv  = lut_hp - CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      wave_d  = wave_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;

      case (state_q)
         StSilent: begin
            if (lut_valid) begin
               state_d = StPlay;
               cur_d   = bus.note_in;
               wave_d  = 1'b1;
               cnt_d   = lut_hp - CNT_W'(1);
            end
         end

         StPlay: begin
            wave_d = wave_adv;
            cnt_d  = cnt_adv;
            if (bus.note_in != cur_q) begin
               pend_d  = bus.note_in;
               state_d = StPend;
            end
         end

         StPend: begin
            if (bus.note_in == cur_q) begin
               // Change withdrawn before the period ended.
               pend_d  = NOTE_SILENT;
               state_d = StPlay;
               wave_d  = wave_adv;
               cnt_d   = cnt_adv;
            end else if (pend_apply) begin
               pend_d = NOTE_SILENT;
               if (lut_valid) begin
                  state_d = StPlay;
                  cur_d   = pend_q;
                  wave_d  = 1'b1;
                  cnt_d   = lut_hp - CNT_W'(1);
               end else begin
                  // Silence and unused codes end the tone with the output already low.
                  state_d = StSilent;
                  cur_d   = NOTE_SILENT;
                  wave_d  = 1'b0;
                  cnt_d   = '0;
               end
            end else begin
               pend_d = bus.note_in;
               wave_d = wave_adv;
               cnt_d  = cnt_adv;
            end
         end

         default: begin
            state_d = StSilent;
            wave_d  = 1'b0;
            cur_d   = NOTE_SILENT;
            cnt_d   = '0;
            pend_d  = NOTE_SILENT;
         end
      endcase

      // Mute wins over every other event in the same cycle.
      if (bus.mute) begin
         state_d = StSilent;
         wave_d  = 1'b0;
         cur_d   = NOTE_SILENT;
         cnt_d   = '0;
         pend_d  = NOTE_SILENT;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StSilent;
         wave_q  <= 1'b0;
         cur_q   <= NOTE_SILENT;
         cnt_q   <= '0;
         pend_q  <= NOTE_SILENT;
      end else begin
         state_q <= state_d;
         wave_q  <= wave_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.wave_out    = wave_q;
   assign bus.tone_active = (state_q != StSilent);
   assign bus.cur_note    = cur_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: two instances (DIV_SHIFT 0 and 4) share clock, reset and stimulus.
// A cycle model of the tone behaviour is checked against both on every falling edge, and the
// directed sequence adds literal expectations for latencies and level durations.
`timescale 1ns/1ps
module tb_note_tone_gen;

   localparam int Tbl [13] = '{19111, 18039, 17026, 16071, 15169, 14317,
                               13514, 12755, 12039, 11364, 10726, 10124, 9556};
   localparam int Shift [2] = '{0, 4};

   logic clk   = 1'b0;
   logic n_rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   note_tone_gen_if if0 ();
   note_tone_gen_if if4 ();

   note_tone_gen #(
      .DIV_SHIFT (0),
      .CNT_W     (15)
   ) dut0 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (if0)
   );

   note_tone_gen #(
      .DIV_SHIFT (4),
      .CNT_W     (15)
   ) dut4 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (if4)
   );

   always #50 clk = ~clk;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 20) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   // which: 0 = wave_out, 1 = tone_active, 2 = cur_note
   function automatic logic [31:0] out_of(input int k, input int which);
      if (k == 0) begin
         if (which == 0) return 32'(if0.wave_out);
         if (which == 1) return 32'(if0.tone_active);
         return 32'(if0.cur_note);
      end
      if (which == 0) return 32'(if4.wave_out);
      if (which == 1) return 32'(if4.tone_active);
      return 32'(if4.cur_note);
   endfunction

   task automatic set_in(input logic [3:0] n, input logic m);
      if0.note_in = n;
      if4.note_in = n;
      if0.mute    = m;
      if4.mute    = m;
   endtask

   // ---------------------------------------------------------------- model
   // Tone described as: playing or not, current note, current level and cycles left in it,
   // plus an optional requested note that takes effect when a low level runs out.
   int m_play [2];
   int m_cur  [2];
   int m_lvl  [2];
   int m_left [2];
   int m_req  [2];
   int m_has  [2];

   function automatic int half(input int k, input int n);
      return Tbl[n] >> Shift[k];
   endfunction

   task automatic model_reset(input int k);
      m_play[k] = 0;
      m_cur[k]  = 15;
      m_lvl[k]  = 0;
      m_left[k] = 0;
      m_req[k]  = 15;
      m_has[k]  = 0;
   endtask

   task automatic model_level(input int k);
      if (m_left[k] == 1) begin
         m_lvl[k]  = 1 - m_lvl[k];
         m_left[k] = half(k, m_cur[k]);
      end else begin
         m_left[k] = m_left[k] - 1;
      end
   endtask

   task automatic model_step(input int k, input int n, input int m);
      if (m != 0) begin
         model_reset(k);
      end else if (m_play[k] == 0) begin
         if (n <= 12) begin
            m_play[k] = 1;
            m_cur[k]  = n;
            m_lvl[k]  = 1;
            m_left[k] = half(k, n);
         end
      end else if (m_has[k] != 0 && n == m_cur[k]) begin
         m_has[k] = 0;
         model_level(k);
      end else if (m_has[k] != 0 && m_lvl[k] == 0 && m_left[k] == 1) begin
         m_has[k] = 0;
         if (m_req[k] <= 12) begin
            m_cur[k]  = m_req[k];
            m_lvl[k]  = 1;
            m_left[k] = half(k, m_req[k]);
         end else begin
            model_reset(k);
         end
      end else begin
         model_level(k);
         if (n != m_cur[k]) begin
            m_has[k] = 1;
            m_req[k] = n;
         end
      end
   endtask

   // ---------------------------------------------------------------- compare process
   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (n_rst) model_step(k, int'(if0.note_in), int'(if0.mute));
            else       model_reset(k);
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!n_rst) model_reset(k);
            check($sformatf("model[%0d] wave_out", k),    out_of(k, 0), 32'(m_lvl[k]));
            check($sformatf("model[%0d] tone_active", k), out_of(k, 1), 32'(m_play[k]));
            check($sformatf("model[%0d] cur_note", k),    out_of(k, 2), 32'(m_cur[k]));
         end
      end
   end

   // ---------------------------------------------------------------- directed sequence
   task automatic wait_level(input int k, input int lvl, input int limit, input string name);
      int i = 0;
      while (out_of(k, 0) !== 32'(lvl) && i < limit) begin
         @(negedge clk);
         i++;
      end
      check(name, out_of(k, 0), 32'(lvl));
   endtask

   // Counts falling edges, starting with the current one, while the wave holds lvl.
   task automatic count_level(input int k, input int lvl, input int limit, output int n);
      n = 0;
      while (out_of(k, 0) === 32'(lvl) && n < limit) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_silent(input int k, input string name);
      check({name, " wave_out"},    out_of(k, 0), 0);
      check({name, " tone_active"}, out_of(k, 1), 0);
      check({name, " cur_note"},    out_of(k, 2), 15);
   endtask

   initial begin
      int n;
      set_in(4'hF, 1'b0);
      #5 n_rst = 1'b0;
      repeat (3) @(negedge clk);
      check_silent(0, "reset dut0");
      check_silent(1, "reset dut4");
      #2 n_rst = 1'b1;
      @(negedge clk);

      // A4 at full scale: 1-cycle latency, 11364/11364 levels.
      set_in(4'd9, 1'b0);
      @(negedge clk);
      check("a4 rise latency", out_of(0, 0), 1);
      check("a4 cur_note", out_of(0, 2), 9);
      check("a4 tone_active", out_of(0, 1), 1);
      count_level(0, 1, 30000, n);
      check("a4 high cycles", 32'(n), 11364);
      count_level(0, 0, 30000, n);
      check("a4 low cycles", 32'(n), 11364);

      // Switch to C4 mid-high: A4 period completes, then C4 high lasts 19111.
      repeat (100) @(negedge clk);
      set_in(4'd0, 1'b0);
      wait_level(0, 0, 30000, "a4 final fall");
      check("a4 kept until period end", out_of(0, 2), 9);
      wait_level(0, 1, 30000, "c4 rise");
      check("c4 cur_note", out_of(0, 2), 0);
      count_level(0, 1, 30000, n);
      check("c4 high cycles", 32'(n), 19111);

      // Reset pulse mid-tone acts immediately.
      set_in(4'hF, 1'b0);
      repeat (10) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      check_silent(0, "async reset dut0");
      check_silent(1, "async reset dut4");
      @(negedge clk);
      #2 n_rst = 1'b1;
      @(negedge clk);

      // Unused codes keep the generator silent.
      set_in(4'd13, 1'b0);
      repeat (20) @(negedge clk);
      check_silent(0, "code13 dut0");
      check_silent(1, "code13 dut4");
      set_in(4'd14, 1'b0);
      repeat (20) @(negedge clk);
      check_silent(1, "code14 dut4");

      // A4 at DIV_SHIFT=4 (710), silence requested mid-high: low half finishes, then silent.
      set_in(4'd9, 1'b0);
      @(negedge clk);
      check("a4/16 rise latency", out_of(1, 0), 1);
      repeat (300) @(negedge clk);
      set_in(4'hF, 1'b0);
      wait_level(1, 0, 2000, "a4/16 fall");
      n = 0;
      while (out_of(1, 1) === 32'd1 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("a4/16 last low cycles", 32'(n), 710);
      check_silent(1, "a4/16 after silence");
      repeat (50) @(negedge clk);
      check_silent(1, "a4/16 stays silent");

      // D4 at DIV_SHIFT=4 (1064) with a 2->5->2 glitch inside the high level.
      set_in(4'd2, 1'b0);
      @(negedge clk);
      check("d4 rise latency", out_of(1, 0), 1);
      repeat (100) @(negedge clk);
      set_in(4'd5, 1'b0);
      repeat (3) @(negedge clk);
      set_in(4'd2, 1'b0);
      count_level(1, 1, 3000, n);
      check("d4 high cycles with glitch", 32'(n + 103), 1064);
      count_level(1, 0, 3000, n);
      check("d4 low cycles", 32'(n), 1064);
      check("d4 cur_note kept", out_of(1, 2), 2);

      // C5 at DIV_SHIFT=4 (597), then a single-cycle mute.
      set_in(4'd12, 1'b0);
      wait_level(1, 0, 3000, "d4 fall before c5");
      wait_level(1, 1, 3000, "c5 rise");
      check("c5 cur_note", out_of(1, 2), 12);
      count_level(1, 1, 3000, n);
      check("c5 high cycles", 32'(n), 597);
      count_level(1, 0, 3000, n);
      check("c5 low cycles", 32'(n), 597);
      repeat (10) @(negedge clk);
      set_in(4'd12, 1'b1);
      @(negedge clk);
      check_silent(1, "mute");
      set_in(4'd12, 1'b0);
      @(negedge clk);
      check("mute release restart", out_of(1, 0), 1);
      check("mute release cur_note", out_of(1, 2), 12);
      count_level(1, 1, 3000, n);
      check("c5 high after mute", 32'(n), 597);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
